// File: rtl/hazard_stall_unit.sv
// Pipeline-control unit for the 5-stage core: detects hazards that bypassing cannot cover and
// produces stall/bubble/freeze/flush enables, sequencing multi-cycle stalls and memory waits.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module hazard_stall_unit #(
  parameter int unsigned REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
  parameter logic [6:0]  BRANCH_OPCODE  = 7'b1100011,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                IF_ID_inst_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  input  logic                      ID_EX_mem_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic                      EX_MEM_mem_rd_en,
  input  logic                      EX_MEM_mem_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
  input  logic                      dmem_ready,
  input  logic                      branch_taken,
  output logic                      pc_wr_en,
  output logic                      IF_ID_wr_en,
  output logic                      IF_ID_flush,
  output logic                      ID_EX_bubble,
  output logic                      pipe_freeze,
  output logic [CNT_WIDTH-1:0]      stall_cycles
);

  typedef enum logic [1:0] {RUN, STALL, MEM_WAIT} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_stall, do_freeze, do_flush;
  logic       is_branch, lu, lb1, lb2, mw;

  function automatic logic reg_match(input logic [REG_ADDR_WIDTH-1:0] rd,
                                     input logic [REG_ADDR_WIDTH-1:0] rs1,
                                     input logic [REG_ADDR_WIDTH-1:0] rs2);
    return (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

  always_comb begin
    is_branch = (IF_ID_inst_opcode == BRANCH_OPCODE);
    lu        = ID_EX_mem_rd_en && reg_match(ID_EX_rd, IF_ID_rs1, IF_ID_rs2);
    lb2       = is_branch && lu;
    lb1       = is_branch && EX_MEM_mem_rd_en && reg_match(EX_MEM_rd, IF_ID_rs1, IF_ID_rs2);
    mw        = (EX_MEM_mem_rd_en || EX_MEM_mem_wr_en) && !dmem_ready;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_stall  = 1'b0;
    do_freeze = 1'b0;
    do_flush  = 1'b0;
    case (state_q)
      RUN: begin
        if (mw) begin
          do_freeze = 1'b1;
          state_d   = MEM_WAIT;
        end else if (lb2) begin
          do_stall = 1'b1;
          state_d  = STALL;
          cnt_d    = 2'd1;
        end else if (lu || lb1) begin
          do_stall = 1'b1;
        end else if (branch_taken) begin
          do_flush = 1'b1;
        end
      end
      STALL: begin
        if (mw) begin
          do_freeze = 1'b1;
          state_d   = MEM_WAIT;
        end else begin
          do_stall = 1'b1;
          if (cnt_q <= 2'd1) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      MEM_WAIT: begin
        // Release cycle: a pending stall keeps IF/ID held; otherwise behave as RUN without
        // starting a new sequence (a leftover load->branch is then caught as LB1).
        if (!dmem_ready) begin
          do_freeze = 1'b1;
        end else if (cnt_q != '0) begin
          do_stall = 1'b1;
          state_d  = STALL;
        end else begin
          state_d = RUN;
          if (lu || lb1) do_stall = 1'b1;
          else if (branch_taken) do_flush = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    if (!rst_n) begin
      pc_wr_en     = 1'b0;
      IF_ID_wr_en  = 1'b0;
      IF_ID_flush  = 1'b0;
      ID_EX_bubble = 1'b1;
      pipe_freeze  = 1'b0;
    end else begin
      pc_wr_en     = !(do_stall || do_freeze);
      IF_ID_wr_en  = !(do_stall || do_freeze);
      IF_ID_flush  = do_flush;
      ID_EX_bubble = do_stall;
      pipe_freeze  = do_freeze;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      stall_cycles <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_wr_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: driver pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares the control outputs and the stall counter.
module tb_hazard_stall_unit;

  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] ALU = 7'b0110011;
  // {pc_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_bubble, pipe_freeze}
  localparam logic [4:0] RUNO = 5'b11000;
  localparam logic [4:0] STL  = 5'b00010;
  localparam logic [4:0] FRZ  = 5'b00001;
  localparam logic [4:0] FLS  = 5'b11100;
  localparam logic [4:0] RST  = 5'b00010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = ALU;
  logic [4:0] rs1 = '0, rs2 = '0, id_ex_rd = '0, ex_mem_rd = '0;
  logic       id_ex_ld = 1'b0, ex_mem_ld = 1'b0, ex_mem_st = 1'b0;
  logic       dmem_ready = 1'b1, branch_taken = 1'b0;
  logic       pc_wr_en, if_id_wr_en, if_id_flush, id_ex_bubble, pipe_freeze;
  logic [3:0] stall_cycles;

  typedef struct {
    string      name;
    logic [8:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.REG_ADDR_WIDTH(5), .BRANCH_OPCODE(BEQ), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_inst_opcode(opcode), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
    .ID_EX_mem_rd_en(id_ex_ld), .ID_EX_rd(id_ex_rd),
    .EX_MEM_mem_rd_en(ex_mem_ld), .EX_MEM_mem_wr_en(ex_mem_st), .EX_MEM_rd(ex_mem_rd),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .pc_wr_en(pc_wr_en), .IF_ID_wr_en(if_id_wr_en), .IF_ID_flush(if_id_flush),
    .ID_EX_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze), .stall_cycles(stall_cycles)
  );

  always @(negedge clk) begin
    exp_t       e;
    logic [8:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {pc_wr_en, if_id_wr_en, if_id_flush, id_ex_bubble, pipe_freeze, stall_cycles};
      n_cmp++;
      if (act !== e.v) begin
        n_err++;
        $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 e.name, act[8:4], act[3:0], e.v[8:4], e.v[3:0]);
      end
    end
  end

  task automatic set_in(input logic [6:0] op, input logic [4:0] s1, input logic [4:0] s2,
                        input logic il, input logic [4:0] ird,
                        input logic ml, input logic ms, input logic [4:0] mrd,
                        input logic rdy, input logic bt);
    opcode = op; rs1 = s1; rs2 = s2; id_ex_ld = il; id_ex_rd = ird;
    ex_mem_ld = ml; ex_mem_st = ms; ex_mem_rd = mrd; dmem_ready = rdy; branch_taken = bt;
  endtask

  task automatic idle();
    set_in(ALU, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic step(input string name, input logic [4:0] ctl, input logic [3:0] cnt);
    exp_t e;
    e.name = name;
    e.v    = {ctl, cnt};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    step("reset_state", RST, 4'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int wait_cyc;
    @(posedge clk);
    #1;

    // lw x5; add x6,x5,x2
    do_reset();
    set_in(ALU, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    step("lu_stall", STL, 4'd0);
    set_in(ALU, 5'd5, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
    step("lu_release", RUNO, 4'd1);
    idle();
    step("lu_count", RUNO, 4'd1);

    // lw x5; beq x5,x0 -- branch_taken during the stall must be ignored
    do_reset();
    set_in(BEQ, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    step("lb2_stall1", STL, 4'd0);
    set_in(BEQ, 5'd5, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    step("lb2_stall2", STL, 4'd1);
    set_in(BEQ, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    step("lb2_flush", FLS, 4'd2);
    idle();
    step("lb2_after", RUNO, 4'd2);

    // add x5; beq x5,x6 -- bypassed, taken branch flushes at once
    do_reset();
    set_in(BEQ, 5'd5, 5'd6, 1'b0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    step("alu_br_flush", FLS, 4'd0);
    idle();
    step("alu_br_after", RUNO, 4'd0);

    // store in MEM waits 3 cycles, then load to x0 with x0 consumer
    do_reset();
    set_in(ALU, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    step("sw_freeze1", FRZ, 4'd0);
    step("sw_freeze2", FRZ, 4'd1);
    step("sw_freeze3", FRZ, 4'd2);
    dmem_ready = 1'b1;
    step("sw_release", RUNO, 4'd3);
    set_in(ALU, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    step("ld_x0_nostall", RUNO, 4'd3);

    // LB2 stall, load misses in MEM during STALL, then reset mid-freeze
    do_reset();
    set_in(BEQ, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    step("lb2mw_stall", STL, 4'd0);
    set_in(BEQ, 5'd5, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0);
    step("lb2mw_freeze1", FRZ, 4'd1);
    step("lb2mw_freeze2", FRZ, 4'd2);
    dmem_ready = 1'b1;
    step("lb2mw_ready", STL, 4'd3);
    set_in(BEQ, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    step("lb2mw_remain", STL, 4'd4);
    step("lb2mw_flush", FLS, 4'd5);
    set_in(ALU, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0);
    step("mid_freeze", FRZ, 4'd5);
    rst_n = 1'b0;
    step("reset_mid_freeze", RST, 4'd0);
    rst_n = 1'b1;
    idle();
    step("post_reset_run", RUNO, 4'd0);

    // saturation of the 4-bit counter
    do_reset();
    set_in(ALU, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 20; i++) begin
      step("sat_stall", STL, (i > 15) ? 4'hF : 4'(i));
    end
    idle();
    step("sat_hold", RUNO, 4'hF);

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
